sdes_arbiter: RTL and testbench

SDES_ARBITER -- requirements
Module: sdes_arbiter

---
 rtl/sdes_arbiter.sv | 138 +++++++++++++
 tb/tb_sdes_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdes_arbiter.sv
// sdes_arbiter: lets two requesters (A and B) share one external SDES core.
// Requests are arbitrated round-robin. The winner's request is latched and
// presented to the core for CORE_LAT cycles. The captured result is then held
// until the owning requester takes it.
module sdes_arbiter #(
   parameter int CORE_LAT = 1   // core settle time in cycles, legal range 1..15
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       a_valid,
   input  logic       b_valid,
   output logic       a_ready,
   output logic       b_ready,
   input  logic [7:0] a_data,
   input  logic [7:0] b_data,
   input  logic [9:0] a_key,
   input  logic [9:0] b_key,
   input  logic       a_enc,
   input  logic       b_enc,
   output logic       a_rsp_valid,
   output logic       b_rsp_valid,
   input  logic       a_rsp_ready,
   input  logic       b_rsp_ready,
   output logic [7:0] rsp_data,
   output logic [9:0] core_key,
   output logic [7:0] core_plaintext,
   output logic       core_encrypt,
   input  logic [7:0] core_ciphertext,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} stateType;

   localparam logic       GRANT_A  = 1'b0;
   localparam logic       GRANT_B  = 1'b1;
   localparam logic [3:0] LAT_LOAD = 4'(CORE_LAT);

   stateType   state;
   stateType   nextState;
   logic       lastGrant;    // requester of the most recent accept (the current owner outside IDLE)
   logic       winner;
   logic       accept;
   logic       ownerReady;
   logic [3:0] count;
   logic [7:0] dataReg;
   logic [9:0] keyReg;
   logic       encReg;
   logic [7:0] rspReg;

   // Round-robin pick: a lone requester wins; on a tie, the requester that did not win last wins.
   always_comb begin
      winner = GRANT_A;
      if (a_valid && b_valid) begin
         winner = ~lastGrant;
      end else if (b_valid) begin
         winner = GRANT_B;
      end
   end

   // Next state and handshake outputs; requests are only offered in IDLE while not in reset.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
      nextState   = state;
      a_ready     = 1'b0;
      b_ready     = 1'b0;
      a_rsp_valid = 1'b0;
      b_rsp_valid = 1'b0;
      accept      = 1'b0;
      busy        = (state != IDLE);
      ownerReady  = (lastGrant == GRANT_B) ? b_rsp_ready : a_rsp_ready;
      case (state)
         IDLE: begin
            if (!RST) begin
               a_ready = a_valid && (winner == GRANT_A);
               b_ready = b_valid && (winner == GRANT_B);
               accept  = a_ready || b_ready;
               if (accept) begin
                  nextState = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (count == 4'd1) begin
               nextState = RESP;
            end
         end
         RESP: begin
            // The non-owner's rsp_ready is ignored; only the owner can release RESP.
            a_rsp_valid = !RST && (lastGrant == GRANT_A);
            b_rsp_valid = !RST && (lastGrant == GRANT_B);
            if (ownerReady) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // State register; reset returns to IDLE and abandons any operation in flight.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Request latch, grant history, latency counter and result capture.
   always_ff @(posedge CLK) begin
      if (RST) begin
         lastGrant <= GRANT_B;   // A wins the first tie after reset
         count     <= 4'd0;
         dataReg   <= 8'd0;
         keyReg    <= 10'd0;
         encReg    <= 1'b0;
         rspReg    <= 8'd0;
      end else if (accept) begin
         lastGrant <= winner;
         count     <= LAT_LOAD;
         dataReg   <= (winner == GRANT_B) ? b_data : a_data;
         keyReg    <= (winner == GRANT_B) ? b_key  : a_key;
         encReg    <= (winner == GRANT_B) ? b_enc  : a_enc;
      end else if (state == ISSUE) begin
         count <= count - 4'd1;
         if (count == 4'd1) begin
            rspReg <= core_ciphertext;
         end
      end
   end

   // The core sees only latched values, so its inputs stay stable through ISSUE and RESP.
   assign core_key       = keyReg;
   assign core_plaintext = dataReg;
   assign core_encrypt   = encReg;
   assign rsp_data       = rspReg;

endmodule

// File: tb/tb_sdes_arbiter.sv
// tb_sdes_arbiter: runs two arbiters side by side, one with CORE_LAT=1 (unit 0)
// and one with CORE_LAT=3 (unit 1). Each arbiter has its own behavioural S-DES core.
// Inputs are driven after the falling edge, and outputs are sampled 1 time unit later.
module tb_sdes_arbiter;

   logic       CLK = 1'b0;
   logic [1:0] rst;
   logic [1:0] aValid, bValid, aEnc, bEnc, aRspReady, bRspReady;
   logic [7:0] aData [2];
   logic [7:0] bData [2];
   logic [9:0] aKey [2];
   logic [9:0] bKey [2];
   logic [1:0] aReady, bReady, aRspValid, bRspValid, coreEnc, busy;
   logic [7:0] rspData [2];
   logic [7:0] corePlain [2];
   logic [7:0] coreCipher [2];
   logic [9:0] coreKey [2];

   int nCompared = 0;
   int nMismatch = 0;

   always #5 CLK = ~CLK;

   // S-DES reference: S-boxes indexed by {row, col}
   localparam logic [1:0] S0_TAB [16] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                                          2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};
   localparam logic [1:0] S1_TAB [16] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
                                          2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};

   function automatic logic [7:0] p8(input logic [9:0] c);
      return {c[4], c[7], c[3], c[6], c[2], c[5], c[0], c[1]};
   endfunction

   function automatic logic [7:0] fK(input logic [7:0] t, input logic [7:0] sk);
      logic [7:0] x;
      logic [3:0] s;
      x = {t[0], t[3], t[2], t[1], t[2], t[1], t[0], t[3]} ^ sk;
      s = {S0_TAB[{x[7], x[4], x[6], x[5]}], S1_TAB[{x[3], x[0], x[2], x[1]}]};
      return {t[7:4] ^ {s[2], s[0], s[1], s[3]}, t[3:0]};
   endfunction

   function automatic logic [7:0] sdesRef(input logic [7:0] d, input logic [9:0] k, input logic enc);
      logic [9:0] p10, ls1, ls2;
      logic [7:0] k1, k2, t;
      p10 = {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
      ls1 = {p10[8:5], p10[9], p10[3:0], p10[4]};
      ls2 = {ls1[7:5], ls1[9:8], ls1[2:0], ls1[4:3]};
      k1  = p8(ls1);
      k2  = p8(ls2);
      t   = {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
      t   = fK(t, enc ? k1 : k2);
      t   = {t[3:0], t[7:4]};
      t   = fK(t, enc ? k2 : k1);
      return {t[4], t[7], t[5], t[3], t[1], t[6], t[0], t[2]};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : gUnit
      sdes_arbiter #(.CORE_LAT(g == 0 ? 1 : 3)) dut (
         .CLK            (CLK),
         .RST            (rst[g]),
         .a_valid        (aValid[g]),
         .b_valid        (bValid[g]),
         .a_ready        (aReady[g]),
         .b_ready        (bReady[g]),
         .a_data         (aData[g]),
         .b_data         (bData[g]),
         .a_key          (aKey[g]),
         .b_key          (bKey[g]),
         .a_enc          (aEnc[g]),
         .b_enc          (bEnc[g]),
         .a_rsp_valid    (aRspValid[g]),
         .b_rsp_valid    (bRspValid[g]),
         .a_rsp_ready    (aRspReady[g]),
         .b_rsp_ready    (bRspReady[g]),
         .rsp_data       (rspData[g]),
         .core_key       (coreKey[g]),
         .core_plaintext (corePlain[g]),
         .core_encrypt   (coreEnc[g]),
         .core_ciphertext(coreCipher[g]),
         .busy           (busy[g])
      );
      assign coreCipher[g] = sdesRef(corePlain[g], coreKey[g], coreEnc[g]);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic nextCycle();
      @(negedge CLK);
      #1;
   endtask

   // Issue one lone request on unit u and follow it through to the handshake.
   task automatic runReq(input int u, input int lat, input logic useB, input logic [7:0] d,
                         input logic [9:0] k, input logic e, input logic [7:0] expRsp, input string tag);
      if (useB) begin
         bValid[u] = 1'b1; bData[u] = d; bKey[u] = k; bEnc[u] = e;
      end else begin
         aValid[u] = 1'b1; aData[u] = d; aKey[u] = k; aEnc[u] = e;
      end
      aRspReady[u] = 1'b1;
      bRspReady[u] = 1'b1;
      #1;
      check({tag, " ready"}, {aReady[u], bReady[u]}, useB ? 2'b01 : 2'b10);
      nextCycle();
      aValid[u] = 1'b0;
      bValid[u] = 1'b0;
      #1;
      check({tag, " core_key"}, coreKey[u], k);
      check({tag, " core_plaintext"}, corePlain[u], d);
      check({tag, " core_encrypt"}, coreEnc[u], e);
      for (int c = 1; c <= lat; c++) begin
         check({tag, " rsp_valid early"}, {aRspValid[u], bRspValid[u]}, 2'b00);
         nextCycle();
      end
      check({tag, " rsp_valid"}, {aRspValid[u], bRspValid[u]}, useB ? 2'b01 : 2'b10);
      check({tag, " rsp_data"}, rspData[u], expRsp);
      nextCycle();
      check({tag, " busy after"}, busy[u], 1'b0);
   endtask

   typedef struct {
      logic       useB;
      logic [7:0] data;
      logic [9:0] key;
      logic       enc;
      logic [7:0] expRsp;
   } vecType;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecType     vecs [6];
      logic       expB;
      logic [7:0] held;

      vecs[0] = '{1'b0, 8'h97, 10'h282, 1'b1, 8'h38};
      vecs[1] = '{1'b0, 8'h38, 10'h282, 1'b0, 8'h97};
      vecs[2] = '{1'b1, 8'h97, 10'h282, 1'b1, 8'h38};
      vecs[3] = '{1'b1, 8'hA5, 10'h155, 1'b1, sdesRef(8'hA5, 10'h155, 1'b1)};
      vecs[4] = '{1'b0, 8'h00, 10'h000, 1'b1, sdesRef(8'h00, 10'h000, 1'b1)};
      vecs[5] = '{1'b1, 8'hFF, 10'h3FF, 1'b0, sdesRef(8'hFF, 10'h3FF, 1'b0)};

      rst = 2'b11;
      aValid = '0; bValid = '0; aEnc = '0; bEnc = '0; aRspReady = '0; bRspReady = '0;
      for (int u = 0; u < 2; u++) begin
         aData[u] = '0; bData[u] = '0; aKey[u] = '0; bKey[u] = '0;
      end

      // While RST is high, a request must not be offered a ready or be accepted.
      nextCycle();
      aValid[0] = 1'b1;
      #1;
      check("ready during reset", aReady[0], 1'b0);
      nextCycle();
      rst = 2'b00;
      aValid[0] = 1'b0;
      #1;
      for (int u = 0; u < 2; u++) begin
         check($sformatf("u%0d reset busy", u), busy[u], 1'b0);
         check($sformatf("u%0d reset rsp_valid", u), {aRspValid[u], bRspValid[u]}, 2'b00);
         check($sformatf("u%0d reset rsp_data", u), rspData[u], 8'h00);
         check($sformatf("u%0d reset core_key", u), coreKey[u], 10'h000);
         check($sformatf("u%0d reset core_plaintext", u), corePlain[u], 8'h00);
         check($sformatf("u%0d reset core_encrypt", u), coreEnc[u], 1'b0);
      end

      // Both requesters hold valid after reset: grants alternate A, B, A, B.
      aValid[0] = 1'b1; aData[0] = 8'h97; aKey[0] = 10'h282; aEnc[0] = 1'b1;
      bValid[0] = 1'b1; bData[0] = 8'h38; bKey[0] = 10'h282; bEnc[0] = 1'b0;
      aRspReady[0] = 1'b1; bRspReady[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expB = (i % 2) == 1;
         #1;
         check($sformatf("rr%0d grant", i), {aReady[0], bReady[0]}, expB ? 2'b01 : 2'b10);
         nextCycle();
         check($sformatf("rr%0d issue ready", i), {aReady[0], bReady[0]}, 2'b00);
         nextCycle();
         check($sformatf("rr%0d rsp_valid", i), {aRspValid[0], bRspValid[0]}, expB ? 2'b01 : 2'b10);
         check($sformatf("rr%0d rsp_data", i), rspData[0], expB ? 8'h97 : 8'h38);
         nextCycle();
      end
      aValid[0] = 1'b0;
      bValid[0] = 1'b0;
      #1;

      // Table of lone requests on the CORE_LAT=1 unit.
      for (int i = 0; i < 6; i++) begin
         runReq(0, 1, vecs[i].useB, vecs[i].data, vecs[i].key, vecs[i].enc, vecs[i].expRsp,
                $sformatf("vec%0d", i));
      end

      // Reset during ISSUE aborts the request; a later request still works.
      aValid[0] = 1'b1; aData[0] = 8'h97; aKey[0] = 10'h282; aEnc[0] = 1'b1;
      #1;
      check("abort accept", aReady[0], 1'b1);
      nextCycle();
      aValid[0] = 1'b0;
      rst[0] = 1'b1;
      #1;
      check("abort in issue", busy[0], 1'b1);
      nextCycle();
      rst[0] = 1'b0;
      #1;
      check("abort busy", busy[0], 1'b0);
      check("abort rsp_data cleared", rspData[0], 8'h00);
      check("abort core_key cleared", coreKey[0], 10'h000);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("abort no rsp_valid %0d", c), {aRspValid[0], bRspValid[0]}, 2'b00);
         nextCycle();
      end
      runReq(0, 1, 1'b0, 8'h38, 10'h282, 1'b0, 8'h97, "post-abort");

      // CORE_LAT=3: the owner stalls RESP for 5 cycles while B waits and B's rsp_ready is ignored.
      held = sdesRef(8'hA5, 10'h155, 1'b1);
      aValid[1] = 1'b1; aData[1] = 8'hA5; aKey[1] = 10'h155; aEnc[1] = 1'b1;
      aRspReady[1] = 1'b0; bRspReady[1] = 1'b0;
      #1;
      check("lat3 a accept", {aReady[1], bReady[1]}, 2'b10);
      nextCycle();
      aValid[1] = 1'b0;
      bValid[1] = 1'b1; bData[1] = 8'h38; bKey[1] = 10'h282; bEnc[1] = 1'b0;
      #1;
      for (int c = 1; c <= 3; c++) begin
         check($sformatf("lat3 issue%0d ready", c), {aReady[1], bReady[1]}, 2'b00);
         check($sformatf("lat3 issue%0d rsp_valid", c), {aRspValid[1], bRspValid[1]}, 2'b00);
         nextCycle();
      end
      bRspReady[1] = 1'b1;
      #1;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("stall%0d rsp_valid", c), {aRspValid[1], bRspValid[1]}, 2'b10);
         check($sformatf("stall%0d rsp_data", c), rspData[1], held);
         check($sformatf("stall%0d b_ready", c), bReady[1], 1'b0);
         check($sformatf("stall%0d core_key", c), coreKey[1], 10'h155);
         nextCycle();
      end
      aRspReady[1] = 1'b1;
      #1;
      check("stall release rsp_valid", {aRspValid[1], bRspValid[1]}, 2'b10);
      nextCycle();
      check("b accept after handshake", {aReady[1], bReady[1]}, 2'b01);
      check("idle between ops", busy[1], 1'b0);
      nextCycle();
      bValid[1] = 1'b0;
      #1;
      for (int c = 1; c <= 3; c++) begin
         check($sformatf("b issue%0d rsp_valid", c), {aRspValid[1], bRspValid[1]}, 2'b00);
         nextCycle();
      end
      check("b rsp_valid", {aRspValid[1], bRspValid[1]}, 2'b01);
      check("b rsp_data", rspData[1], 8'h97);
      nextCycle();
      check("b done busy", busy[1], 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
